muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit that extends the combinational ALU with RISC-V M-extension operations. It covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It processes one bit per cycle with a shift-add multiplier and a restoring divider, both sharing a single 2*XLEN-bit working register. It sits beside the ALU in the execute stage and uses valid/ready handshakes on both sides so the pipeline can stall on it.

---
 rtl/muldiv_unit_pkg.sv | 28 ++
 rtl/muldiv_unit_if.sv | 29 ++
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types and operand-signedness helpers for the iterative M-extension
// multiply/divide unit.
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } muldiv_op_t;

   function automatic logic is_div(input muldiv_op_t op);
      return op inside {DIV, DIVU, REM, REMU};
   endfunction

   function automatic logic a_signed(input muldiv_op_t op);
      return op inside {MULH, MULHSU, DIV, REM};
   endfunction

   function automatic logic b_signed(input muldiv_op_t op);
      return op inside {MULH, DIV, REM};
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface muldiv_unit_if #(
   parameter int XLEN = 64
) ();
   import muldiv_unit_pkg::*;

   logic             in_valid;
   logic             in_ready;
   muldiv_op_t       op;
   logic [XLEN-1:0]  a;
   logic [XLEN-1:0]  b;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  result;
   logic             div_by_zero;
   logic             div_overflow;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, div_by_zero, div_overflow
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, div_by_zero, div_overflow
   );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: one bit per cycle, shift-add multiply and
// restoring divide sharing a single 2*XLEN working register on unsigned magnitudes.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int CW   = $clog2(XLEN + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   muldiv_unit_if.slave  io
);

   typedef enum logic [1:0] {IDLE, ITER, SIGN, DONE} muldiv_state_t;

   localparam logic [XLEN-1:0]   ONE     = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [2*XLEN-1:0] ONE2    = {{(2*XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0]   INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t       state_q, state_d;
   muldiv_op_t          op_q, op_d;
   logic                neg_q, neg_d;
   logic                neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic                dbz_q, dbz_d;
   logic                ovf_q, ovf_d;

   logic                a_neg, b_neg;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     quo, rem;

   // Divide keeps the bit shifted out of the remainder so the trial compare
   // works for divisors above 2^(XLEN-1); multiply keeps the adder carry.
   function automatic logic [2*XLEN-1:0] step(input logic div,
                                              input logic [2*XLEN-1:0] acc,
                                              input logic [XLEN-1:0] opnd);
      logic [XLEN:0] rem_sh;
      logic [XLEN:0] trial;
      logic [XLEN:0] sum;
      rem_sh = acc[2*XLEN-1:XLEN-1];
      trial  = rem_sh - {1'b0, opnd};
      sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
      if (div) begin
         if (!trial[XLEN]) step = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else              step = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
         step = {sum, acc[XLEN-1:1]};
      end
   endfunction

   always_comb begin
      a_neg = a_signed(io.op) & io.a[XLEN-1];
      b_neg = b_signed(io.op) & io.b[XLEN-1];
      a_mag = a_neg ? (~io.a + ONE) : io.a;
      b_mag = b_neg ? (~io.b + ONE) : io.b;
      prod  = neg_q ? (~acc_q + ONE2) : acc_q;
      quo   = neg_q ? (~acc_q[XLEN-1:0] + ONE) : acc_q[XLEN-1:0];
      rem   = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + ONE) : acc_q[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      opnd_d    = opnd_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      dbz_d     = dbz_q;
      ovf_d     = ovf_q;
      if (flush) begin
         state_d = IDLE;
         dbz_d   = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (io.in_valid) begin
                  op_d      = io.op;
                  neg_d     = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  opnd_d    = is_div(io.op) ? b_mag : a_mag;
                  acc_d     = {{XLEN{1'b0}}, (is_div(io.op) ? a_mag : b_mag)};
                  cnt_d     = '0;
                  state_d   = ITER;
                  if (is_div(io.op) && io.b == '0) begin
                     result_d = (io.op inside {DIV, DIVU}) ? {XLEN{1'b1}} : io.a;
                     dbz_d    = 1'b1;
                     state_d  = DONE;
                  end else if ((io.op inside {DIV, REM}) && io.a == INT_MIN && io.b == {XLEN{1'b1}}) begin
                     result_d = (io.op == DIV) ? INT_MIN : '0;
                     ovf_d    = 1'b1;
                     state_d  = DONE;
                  end
               end
            end
            ITER: begin
               acc_d = step(is_div(op_q), acc_q, opnd_q);
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(XLEN - 1)) state_d = SIGN;
            end
            SIGN: begin
               case (op_q)
                  MUL:               result_d = prod[XLEN-1:0];
                  MULH, MULHSU, MULHU: result_d = prod[2*XLEN-1:XLEN];
                  DIV, DIVU:         result_d = quo;
                  default:           result_d = rem;
               endcase
               state_d = DONE;
            end
            DONE: begin
               if (io.out_ready) begin
                  state_d = IDLE;
                  dbz_d   = 1'b0;
                  ovf_d   = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         op_q      <= MUL;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         dbz_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         dbz_q     <= dbz_d;
         ovf_q     <= ovf_d;
      end
   end

   assign io.in_ready     = (state_q == IDLE);
   assign io.out_valid    = (state_q == DONE);
   assign io.result       = result_q;
   assign io.div_by_zero  = dbz_q;
   assign io.div_overflow = ovf_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=64: results, flags, latency,
// backpressure, flush and asynchronous reset, all against hand-computed values.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int XLEN = 64;

   logic clk = 1'b0;
   logic rst_n;
   logic flush = 1'b0;
   int   checks = 0;
   int   errors = 0;

   muldiv_unit_if #(.XLEN(XLEN)) io ();

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .io    (io)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Issue one request; the edge at the end of this task is the accept edge.
   task automatic applyStimulus(input muldiv_op_t op, input logic [63:0] a,
                                input logic [63:0] b);
      int n = 0;
      while (!io.in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      io.op       = op;
      io.a        = a;
      io.b        = b;
      io.in_valid = 1'b1;
      @(posedge clk);
      #1;
      io.in_valid = 1'b0;
   endtask

   task automatic waitResult(output int lat);
      lat = 0;
      while (!io.out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic runOp(input string tag, input muldiv_op_t op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] expRes,
                        input int expLat, input logic expDbz, input logic expOvf);
      int lat;
      applyStimulus(op, a, b);
      waitResult(lat);
      checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
      checkOutput({tag, " result"}, io.result, expRes);
      checkOutput({tag, " div_by_zero"}, 64'(io.div_by_zero), 64'(expDbz));
      checkOutput({tag, " div_overflow"}, 64'(io.div_overflow), 64'(expOvf));
      io.out_ready = 1'b1;
      @(posedge clk);
      #1;
      io.out_ready = 1'b0;
      checkOutput({tag, " in_ready after handshake"}, 64'(io.in_ready), 64'd1);
   endtask

   initial begin
      int lat;
      logic seen;
      io.in_valid  = 1'b0;
      io.out_ready = 1'b0;
      io.op        = MUL;
      io.a         = '0;
      io.b         = '0;
      rst_n        = 1'b1;
      #2 rst_n     = 1'b0;
      #2;
      checkOutput("reset in_ready", 64'(io.in_ready), 64'd1);
      checkOutput("reset out_valid", 64'(io.out_valid), 64'd0);
      checkOutput("reset result", io.result, 64'd0);
      checkOutput("reset flags", {62'd0, io.div_by_zero, io.div_overflow}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      runOp("MUL 7*-3", MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1'b0, 1'b0);
      runOp("MULHU ones", MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0, 1'b0);
      runOp("MULH ones", MULH, '1, '1, 64'h0, 65, 1'b0, 1'b0);
      runOp("MULHSU -1*2", MULHSU, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0, 1'b0);

      runOp("DIV -7/2", DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0, 1'b0);
      runOp("REM -7%2", REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0, 1'b0);
      runOp("DIVU 100/7", DIVU, 64'd100, 64'd7, 64'd14, 65, 1'b0, 1'b0);
      runOp("REMU 100%7", REMU, 64'd100, 64'd7, 64'd2, 65, 1'b0, 1'b0);

      runOp("DIV 5/0", DIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 1'b0);
      runOp("REM 5%0", REM, 64'd5, 64'd0, 64'd5, 0, 1'b1, 1'b0);
      runOp("DIV min/-1", DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0, 1'b0, 1'b1);
      runOp("REM min%-1", REM, 64'h8000_0000_0000_0000, '1, 64'd0, 0, 1'b0, 1'b1);

      // Result must hold while the consumer stalls, and a new request is refused.
      applyStimulus(MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
      waitResult(lat);
      checkOutput("stall latency", 64'(lat), 64'd65);
      io.op       = DIVU;
      io.a        = 64'd100;
      io.b        = 64'd7;
      io.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("stall result", io.result, 64'hFFFF_FFFF_FFFF_FFEB);
         checkOutput("stall in_ready", 64'(io.in_ready), 64'd0);
         checkOutput("stall out_valid", 64'(io.out_valid), 64'd1);
      end
      io.in_valid  = 1'b0;
      io.out_ready = 1'b1;
      @(posedge clk);
      #1;
      io.out_ready = 1'b0;
      checkOutput("release in_ready", 64'(io.in_ready), 64'd1);
      checkOutput("release out_valid", 64'(io.out_valid), 64'd0);

      // Flush ten cycles into a divide; no result may ever appear.
      applyStimulus(DIV, 64'd100, 64'd7);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flush in_ready", 64'(io.in_ready), 64'd1);
      checkOutput("flush out_valid", 64'(io.out_valid), 64'd0);
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (io.out_valid) seen = 1'b1;
      end
      checkOutput("flush no result", 64'(seen), 64'd0);

      io.op       = DIV;
      io.a        = 64'd5;
      io.b        = 64'd0;
      io.in_valid = 1'b1;
      flush       = 1'b1;
      @(posedge clk);
      #1;
      flush       = 1'b0;
      io.in_valid = 1'b0;
      checkOutput("flush beats accept in_ready", 64'(io.in_ready), 64'd1);
      checkOutput("flush beats accept dbz", 64'(io.div_by_zero), 64'd0);

      // Asynchronous reset in the middle of a multiply.
      applyStimulus(MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
      repeat (19) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midop reset in_ready", 64'(io.in_ready), 64'd1);
      checkOutput("midop reset out_valid", 64'(io.out_valid), 64'd0);
      checkOutput("midop reset result", io.result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      runOp("DIVU 9/3", DIVU, 64'd9, 64'd3, 64'd3, 65, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
